// File: rtl/pulse_width_meter.sv
// ----------------------------------------------------------------------------
// pulse_width_meter
//
// Measures the width, in clk cycles, of every high pulse on an asynchronous
// input. Each width is presented as one result on a valid/ready output stream.
// Pulses shorter than MIN_WIDTH are discarded. Pulses longer than the counter
// range saturate at all-ones and set m_overflow.
//
// Parameters:
//   CNT_WIDTH    width of the measurement counter and of m_width
//   MIN_WIDTH    minimum accepted width in cycles; shorter pulses are dropped silently
//   SYNC_STAGES  number of synchroniser flops on din (>= 2)
//
// Ports:
//   clk         single clock, all logic on the rising edge
//   aresetn     asynchronous active-low reset
//   din         asynchronous pulse input
//   m_width     measured high width in cycles (saturating)
//   m_overflow  m_width saturated; the true width exceeds 2**CNT_WIDTH-1
//   m_valid     result available
//   m_ready     consumer takes the result when m_valid && m_ready
//   dropped     1-cycle strobe: a completed result was lost because the output slot was full
// ----------------------------------------------------------------------------
module pulse_width_meter #(
    parameter int CNT_WIDTH   = 16,
    parameter int MIN_WIDTH   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 din,
    output logic [CNT_WIDTH-1:0] m_width,
    output logic                 m_overflow,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 dropped
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        MEASURE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] MIN_W   = CNT_WIDTH'(MIN_WIDTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   din_s;
    logic                   din_d_q;
    logic                   primed;
    logic                   din_rise;
    logic                   slot_free;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   sat_q;

    assign din_s = sync_q[SYNC_STAGES-1];

    // The sync chain resets to zero. Its first outputs after reset release
    // are therefore not real samples of din. prime_q marks when every stage
    // holds a genuine sample. Without it, WAIT_LOW would accept the reset zeros
    // as "din low" and then measure the tail of a pulse that was already high
    // when reset was released.
    assign primed = prime_q[SYNC_STAGES-1];

    // In IDLE, din_d_q is always 0, because IDLE is entered only after din_s
    // was seen low. The rising-edge qualifier therefore matches a plain
    // din_s test, but it states the intent explicitly.
    assign din_rise = din_s & ~din_d_q;

    // The output slot can take a new result if it is empty, or if its current
    // result is being accepted on this same edge.
    assign slot_free = ~m_valid | m_ready;

    // Synchroniser and priming chain.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q  <= '0;
            prime_q <= '0;
            din_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            din_d_q <= din_s;
        end
    end

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= WAIT_LOW;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            m_width    <= '0;
            m_overflow <= 1'b0;
            m_valid    <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            dropped <= 1'b0;

            // Handshake. A load further down overrides this on the same edge,
            // so an accept and a new load produce no bubble.
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state_q)
                WAIT_LOW: begin
                    if (primed && !din_s) begin
                        state_q <= IDLE;
                    end
                end

                IDLE: begin
                    if (din_rise) begin
                        state_q <= MEASURE;
                        cnt_q   <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        sat_q   <= 1'b0;
                    end
                end

                MEASURE: begin
                    if (din_s) begin
                        if (cnt_q == CNT_MAX) begin
                            sat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        // cnt_q now holds the number of cycles din_s was high.
                        state_q <= IDLE;
                        if (cnt_q >= MIN_W) begin
                            if (slot_free) begin
                                m_width    <= cnt_q;
                                m_overflow <= sat_q;
                                m_valid    <= 1'b1;
                            end else begin
                                dropped <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= WAIT_LOW;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
module tb_pulse_width_meter;

    localparam int CW    = 8;
    localparam int MINW  = 3;
    localparam int SYNC  = 2;
    localparam int SATV  = (1 << CW) - 1;
    localparam int N     = 1500;

    logic          clk;
    logic          aresetn;
    logic          din;
    logic [CW-1:0] m_width;
    logic          m_overflow;
    logic          m_valid;
    logic          m_ready;
    logic          dropped;

    int checks   = 0;
    int failures = 0;

    pulse_width_meter #(
        .CNT_WIDTH  (CW),
        .MIN_WIDTH  (MINW),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .din       (din),
        .m_width   (m_width),
        .m_overflow(m_overflow),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a pulse of len cycles with m_ready held high, then watch 8 cycles.
    task automatic pulse_observe(input int len, output int nvalid, output int lat,
                                 output int w, output int o, output int ndrop);
        nvalid = 0; lat = -1; w = -1; o = -1; ndrop = 0;
        din = 1'b1;
        repeat (len) tick();
        din = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (m_valid) begin
                if (nvalid == 0) begin
                    lat = c; w = int'(m_width); o = int'(m_overflow);
                end
                nvalid++;
            end
            if (dropped) ndrop++;
        end
    endtask

    typedef struct {
        int len;
        bit exp_v;
        int exp_w;
        bit exp_o;
    } vec_t;

    vec_t vecs[9];

    // Random-phase stimulus and expected results.
    bit d_arr[N];
    bit r_arr[N];
    bit ev_on[N];
    int ev_w[N];
    bit ev_o[N];

    initial begin
        int nv, lat, w, o, nd;
        int cnt_drop, w_at_drop;

        vecs[0] = '{len: 5,   exp_v: 1, exp_w: 5,   exp_o: 0};
        vecs[1] = '{len: 2,   exp_v: 0, exp_w: 0,   exp_o: 0};
        vecs[2] = '{len: 3,   exp_v: 1, exp_w: 3,   exp_o: 0};
        vecs[3] = '{len: 1,   exp_v: 0, exp_w: 0,   exp_o: 0};
        vecs[4] = '{len: 4,   exp_v: 1, exp_w: 4,   exp_o: 0};
        vecs[5] = '{len: 255, exp_v: 1, exp_w: 255, exp_o: 0};
        vecs[6] = '{len: 256, exp_v: 1, exp_w: 255, exp_o: 1};
        vecs[7] = '{len: 300, exp_v: 1, exp_w: 255, exp_o: 1};
        vecs[8] = '{len: 9,   exp_v: 1, exp_w: 9,   exp_o: 0};

        // Reset state.
        aresetn = 1'b0; din = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_width", m_width, 0);
        chk("reset_m_overflow", m_overflow, 0);
        chk("reset_dropped", dropped, 0);
        aresetn = 1'b1;
        repeat (5) tick();

        // Table-driven single pulses, consumer always ready.
        m_ready = 1'b1;
        foreach (vecs[i]) begin
            pulse_observe(vecs[i].len, nv, lat, w, o, nd);
            $display("vec %0d len=%0d nvalid=%0d width=%0d ovf=%0d latency=%0d dropped=%0d",
                     i, vecs[i].len, nv, w, o, lat, nd);
            chk($sformatf("vec%0d_nvalid", i), nv, vecs[i].exp_v ? 1 : 0);
            chk($sformatf("vec%0d_dropped", i), nd, 0);
            if (vecs[i].exp_v) begin
                chk($sformatf("vec%0d_latency", i), lat, SYNC + 1);
                chk($sformatf("vec%0d_width", i), w, vecs[i].exp_w);
                chk($sformatf("vec%0d_overflow", i), o, int'(vecs[i].exp_o));
            end
        end

        // Slot full: second result is dropped, the first is held.
        m_ready = 1'b0; cnt_drop = 0; w_at_drop = -1;
        din = 1'b1; repeat (4) tick();
        din = 1'b0; repeat (4) tick();
        din = 1'b1; repeat (6) tick();
        din = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (dropped) begin
                cnt_drop++; w_at_drop = int'(m_width);
            end
        end
        $display("seq drop: m_valid=%0d width=%0d drops=%0d", m_valid, m_width, cnt_drop);
        chk("drop_count", cnt_drop, 1);
        chk("drop_width_at_strobe", w_at_drop, 4);
        chk("drop_held_valid", m_valid, 1);
        chk("drop_held_width", m_width, 4);
        m_ready = 1'b1;
        tick();
        chk("drop_accept_clears", m_valid, 0);

        // Accept and load on the same edge: no bubble, no drop.
        m_ready = 1'b0;
        din = 1'b1; repeat (4) tick();
        din = 1'b0; repeat (4) tick();
        chk("swap_first_valid", m_valid, 1);
        din = 1'b1; repeat (6) tick();
        din = 1'b0;
        tick(); tick();
        m_ready = 1'b1;
        tick();
        $display("seq swap: m_valid=%0d width=%0d dropped=%0d", m_valid, m_width, dropped);
        chk("swap_valid", m_valid, 1);
        chk("swap_width", m_width, 6);
        chk("swap_dropped", dropped, 0);
        tick();
        chk("swap_consumed", m_valid, 0);
        repeat (3) tick();

        // din already high at reset release: only the later 7-cycle pulse counts.
        aresetn = 1'b0; din = 1'b1; m_ready = 1'b1;
        repeat (3) tick();
        aresetn = 1'b1;
        nv = 0; w = -1; nd = 0;
        for (int c = 0; c < 30; c++) begin
            din = (c < 5) ? 1'b1 : ((c >= 9 && c < 16) ? 1'b1 : 1'b0);
            tick();
            if (m_valid) begin
                nv++; w = int'(m_width);
            end
            if (dropped) nd++;
        end
        $display("seq high_at_release: nvalid=%0d width=%0d dropped=%0d", nv, w, nd);
        chk("release_nvalid", nv, 1);
        chk("release_width", w, 7);
        chk("release_dropped", nd, 0);

        // Asynchronous reset in the middle of a pulse, with a result pending.
        m_ready = 1'b0;
        din = 1'b1; repeat (4) tick();
        din = 1'b0; repeat (6) tick();
        chk("areset_pre_valid", m_valid, 1);
        din = 1'b1; repeat (10) tick();
        #2;
        aresetn = 1'b0;
        #1;
        $display("seq async_reset: m_valid=%0d width=%0d ovf=%0d dropped=%0d",
                 m_valid, m_width, m_overflow, dropped);
        chk("areset_m_valid", m_valid, 0);
        chk("areset_m_width", m_width, 0);
        chk("areset_m_overflow", m_overflow, 0);
        chk("areset_dropped", dropped, 0);
        repeat (3) tick();
        aresetn = 1'b1;
        m_ready = 1'b1;
        repeat (4) tick();
        din = 1'b0;
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (m_valid) nv++;
        end
        chk("areset_no_result", nv, 0);

        // Randomised run against a pulse-level reference.
        din = 1'b0; m_ready = 1'b1;
        repeat (6) tick();
        begin
            int i;
            i = 0;
            for (int k = 0; k < N; k++) begin
                d_arr[k] = 1'b0;
                r_arr[k] = ($urandom_range(0, 3) != 0);
                ev_on[k] = 1'b0; ev_w[k] = 0; ev_o[k] = 1'b0;
            end
            i = 5;
            while (i < N - 300) begin
                int hl, ll;
                hl = ($urandom_range(0, 15) == 0) ? int'($urandom_range(250, 262))
                                                  : int'($urandom_range(1, 8));
                ll = $urandom_range(1, 4);
                for (int k = 0; k < hl; k++) d_arr[i + k] = 1'b1;
                i += hl + ll;
            end
            // A high run ending at index b completes SYNC+1 edges after din falls.
            for (int b = 0; b < N - 10; b++) begin
                if (d_arr[b] && !d_arr[b + 1]) begin
                    int a;
                    a = b;
                    while (a > 0 && d_arr[a - 1]) a--;
                    if (b - a + 1 >= MINW) begin
                        ev_on[b + SYNC + 1] = 1'b1;
                        ev_w[b + SYNC + 1]  = (b - a + 1 > SATV) ? SATV : (b - a + 1);
                        ev_o[b + SYNC + 1]  = (b - a + 1 > SATV);
                    end
                end
            end
        end
        begin
            bit mv, mo, md;
            int mw;
            mv = 1'b0; mw = 0; mo = 1'b0;
            for (int j = 0; j < N; j++) begin
                bit acc;
                din = d_arr[j];
                m_ready = r_arr[j];
                tick();
                acc = mv && r_arr[j];
                if (acc) $display("rnd txn cycle=%0d width=%0d ovf=%0d", j, mw, mo);
                md = 1'b0;
                if (ev_on[j]) begin
                    if (!mv || acc) begin
                        mv = 1'b1; mw = ev_w[j]; mo = ev_o[j];
                    end else begin
                        md = 1'b1;
                    end
                end else if (acc) begin
                    mv = 1'b0;
                end
                chk($sformatf("rnd_valid@%0d", j), m_valid, mv);
                chk($sformatf("rnd_dropped@%0d", j), dropped, md);
                if (mv) begin
                    chk($sformatf("rnd_width@%0d", j), m_width, mw);
                    chk($sformatf("rnd_overflow@%0d", j), m_overflow, mo);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
